// File: rtl/pcie_vc_switch_if.sv
`default_nettype none
// ============================================================================
// Module   : pcie_vc_switch_if
// Brief    : Control, data and status bundle of the pcie_vc_switch block.
// Revision : 1.0 - initial release
// ============================================================================
interface pcie_vc_switch_if #(
  parameter int DATA_W     = 12,
  parameter int NUM_VC     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 5
);
  localparam int VC_W = $clog2(NUM_VC);
  localparam int TH_W = $clog2(FIFO_DEPTH) + 1;

  logic                     init;
  logic [TH_W-1:0]          umbral_L;
  logic [TH_W-1:0]          umbral_H;
  logic                     push;
  logic [DATA_W-1:0]        data_in;
  logic [NUM_VC-1:0]        pop;
  logic                     req;
  logic [VC_W:0]            idx;
  logic [NUM_VC*DATA_W-1:0] data_out;
  logic [NUM_VC-1:0]        valid_out;
  logic [NUM_VC-1:0]        almost_empty;
  logic [NUM_VC-1:0]        almost_full;
  logic                     ingress_full;
  logic                     idle;
  logic [1:0]               state;
  logic                     err_push;
  logic                     err_pop;
  logic [CNT_W-1:0]         cnt_out;
  logic                     cnt_valid;

  modport master (
    output init, umbral_L, umbral_H, push, data_in, pop, req, idx,
    input  data_out, valid_out, almost_empty, almost_full, ingress_full,
           idle, state, err_push, err_pop, cnt_out, cnt_valid
  );

  modport slave (
    input  init, umbral_L, umbral_H, push, data_in, pop, req, idx,
    output data_out, valid_out, almost_empty, almost_full, ingress_full,
           idle, state, err_push, err_pop, cnt_out, cnt_valid
  );
endinterface
`default_nettype wire

// File: rtl/pcie_vc_switch.sv
`default_nettype none
// ============================================================================
// Module   : pcie_vc_switch
// Brief    : Ingress FIFO routed by destination MSBs into NUM_VC egress FIFOs
//            with threshold flags, backpressure and per-channel word counters.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_vc_switch #(
  parameter int DATA_W     = 12,
  parameter int NUM_VC     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 5
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pcie_vc_switch_if.slave bus
);
  localparam int c_VC_W  = $clog2(NUM_VC);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_TH_W  = c_PTR_W + 1;
  localparam logic [c_TH_W-1:0] c_DEPTH  = c_TH_W'(FIFO_DEPTH);
  localparam logic [c_TH_W-1:0] c_TH_L0  = c_TH_W'(1);
  localparam logic [c_TH_W-1:0] c_TH_H0  = c_TH_W'(FIFO_DEPTH - 1);
  localparam logic [c_VC_W:0]   c_NUM_VC = (c_VC_W + 1)'(NUM_VC);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_TH_W-1:0] r_th_l;
  logic [c_TH_W-1:0] r_th_h;
  logic              r_err_push;
  logic              r_err_pop;
  logic [CNT_W-1:0]  r_cnt_out;
  logic              r_cnt_valid;

  logic [DATA_W-1:0] r_in_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_in_wr;
  logic [c_PTR_W-1:0] r_in_rd;
  logic [c_TH_W-1:0]  r_in_cnt;

  logic [NUM_VC*c_TH_W-1:0] w_eg_cnt_flat;
  logic [NUM_VC*CNT_W-1:0]  w_words_flat;
  logic [NUM_VC-1:0]        w_eg_nonempty;
  logic [NUM_VC-1:0]        w_pop_err;

  logic               w_run;
  logic [DATA_W-1:0]  w_head;
  logic [c_VC_W-1:0]  w_dest;
  logic [c_TH_W-1:0]  w_dst_cnt;
  logic               w_dispatch;
  logic               w_in_full;
  logic               w_push_ok;
  logic               w_any_nonempty;

  assign w_run          = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
  assign w_head         = r_in_mem[r_in_rd];
  assign w_dest         = w_head[DATA_W-1 -: c_VC_W];
  assign w_dst_cnt      = w_eg_cnt_flat[w_dest*c_TH_W +: c_TH_W];
  assign w_in_full      = (r_in_cnt == c_DEPTH);
  // Head-of-line blocking: a stalled head holds every word behind it.
  assign w_dispatch     = w_run && (r_in_cnt != '0) && (w_dst_cnt < r_th_h) &&
                          (w_dst_cnt < c_DEPTH);
  assign w_push_ok      = bus.push && w_run && (!w_in_full || w_dispatch);
  assign w_any_nonempty = (r_in_cnt != '0) || (|w_eg_nonempty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RESET;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET:  w_state_nxt = ST_INIT;
      ST_INIT:   if (!bus.init) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (bus.init)                           w_state_nxt = ST_INIT;
        else if (bus.push || w_any_nonempty)    w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init)                           w_state_nxt = ST_INIT;
        else if (!w_any_nonempty && !bus.push)  w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_in_mem[r_in_wr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_cnt   <= '0;
      r_err_push <= 1'b0;
    end else begin
      if (w_push_ok)  r_in_wr <= r_in_wr + c_PTR_W'(1);
      if (w_dispatch) r_in_rd <= r_in_rd + c_PTR_W'(1);
      case ({w_push_ok, w_dispatch})
        2'b10:   r_in_cnt <= r_in_cnt + c_TH_W'(1);
        2'b01:   r_in_cnt <= r_in_cnt - c_TH_W'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
      if (bus.push && !w_push_ok) r_err_push <= 1'b1;
    end
  end

  genvar c;
  generate
    for (c = 0; c < NUM_VC; c++) begin : g_vc
      logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
      logic [c_PTR_W-1:0] r_wr;
      logic [c_PTR_W-1:0] r_rd;
      logic [c_TH_W-1:0]  r_cnt;
      logic [DATA_W-1:0]  r_dout;
      logic               r_vld;
      logic [CNT_W-1:0]   r_words;
      logic               w_in;
      logic               w_pop_en;
      logic               w_pop_ok;

      assign w_in     = w_dispatch && (w_dest == c_VC_W'(c));
      assign w_pop_en = bus.pop[c] && (r_state != ST_RESET);
      assign w_pop_ok = w_pop_en && (r_cnt != '0);

      always_ff @(posedge clk) begin
        if (w_in) r_mem[r_wr] <= w_head;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_wr    <= '0;
          r_rd    <= '0;
          r_cnt   <= '0;
          r_dout  <= '0;
          r_vld   <= 1'b0;
          r_words <= '0;
        end else begin
          r_vld <= w_pop_ok;
          if (w_in) r_wr <= r_wr + c_PTR_W'(1);
          if (w_pop_ok) begin
            r_dout  <= r_mem[r_rd];
            r_rd    <= r_rd + c_PTR_W'(1);
            r_words <= r_words + CNT_W'(1);
          end
          case ({w_in, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + c_TH_W'(1);
            2'b01:   r_cnt <= r_cnt - c_TH_W'(1);
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      assign w_pop_err[c]                      = w_pop_en && (r_cnt == '0);
      assign w_eg_nonempty[c]                  = (r_cnt != '0);
      assign w_eg_cnt_flat[c*c_TH_W +: c_TH_W] = r_cnt;
      assign w_words_flat[c*CNT_W +: CNT_W]    = r_words;
      assign bus.data_out[c*DATA_W +: DATA_W]  = r_dout;
      assign bus.valid_out[c]                  = r_vld;
      assign bus.almost_empty[c]               = (r_cnt <= r_th_l);
      assign bus.almost_full[c]                = (r_cnt >= r_th_h);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th_l      <= c_TH_L0;
      r_th_h      <= c_TH_H0;
      r_err_pop   <= 1'b0;
      r_cnt_out   <= '0;
      r_cnt_valid <= 1'b0;
    end else begin
      if ((r_state == ST_INIT) && bus.init) begin
        r_th_l <= bus.umbral_L;
        r_th_h <= bus.umbral_H;
      end
      if (|w_pop_err) r_err_pop <= 1'b1;
      // Counters are sampled before any same-edge pop increments them.
      if (bus.req) begin
        if (bus.idx < c_NUM_VC) begin
          r_cnt_out   <= w_words_flat[bus.idx[c_VC_W-1:0]*CNT_W +: CNT_W];
          r_cnt_valid <= 1'b1;
        end else begin
          r_cnt_out   <= '0;
          r_cnt_valid <= 1'b0;
        end
      end else begin
        r_cnt_valid <= 1'b0;
      end
    end
  end

  assign bus.ingress_full = w_in_full;
  assign bus.idle         = (r_state == ST_IDLE);
  assign bus.state        = r_state;
  assign bus.err_push     = r_err_push;
  assign bus.err_pop      = r_err_pop;
  assign bus.cnt_out      = r_cnt_out;
  assign bus.cnt_valid    = r_cnt_valid;
endmodule
`default_nettype wire

// File: tb/tb_pcie_vc_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_vc_switch
// Brief    : Directed scenarios plus random traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_vc_switch;
  localparam int DW  = 12;
  localparam int NV  = 4;
  localparam int DEP = 8;
  localparam int CW  = 5;
  localparam int VW  = $clog2(NV);
  localparam int TW  = $clog2(DEP) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pcie_vc_switch_if #(.DATA_W(DW), .NUM_VC(NV), .FIFO_DEPTH(DEP), .CNT_W(CW)) bus ();

  pcie_vc_switch #(.DATA_W(DW), .NUM_VC(NV), .FIFO_DEPTH(DEP), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: plain queues and sizes, one update per clock edge.
  int              m_st;
  int              m_thl;
  int              m_thh;
  bit              m_err_push;
  bit              m_err_pop;
  int              m_words [NV];
  int              m_co;
  bit              m_cv;
  logic [NV-1:0]   m_vld;
  logic [DW-1:0]   m_in [$];
  logic [DW-1:0]   m_eg [NV][$];
  logic [DW-1:0]   exp_q [NV][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in.delete();
    for (int c = 0; c < NV; c++) begin
      m_eg[c].delete();
      exp_q[c].delete();
      m_words[c] = 0;
    end
    m_st = 0; m_thl = 1; m_thh = DEP - 1;
    m_err_push = 0; m_err_pop = 0;
    m_co = 0; m_cv = 0; m_vld = '0;
  endtask

  task automatic model_step();
    bit run, disp, pok, anyne;
    int d, nst;
    run  = (m_st == 2) || (m_st == 3);
    disp = 0;
    d    = 0;
    if (run && m_in.size() > 0) begin
      d    = int'(m_in[0][DW-1 -: VW]);
      disp = (m_eg[d].size() < m_thh) && (m_eg[d].size() < DEP);
    end
    pok   = bus.push && run && ((m_in.size() < DEP) || disp);
    anyne = (m_in.size() > 0);
    for (int c = 0; c < NV; c++) if (m_eg[c].size() > 0) anyne = 1;
    case (m_st)
      0:       nst = 1;
      1:       nst = bus.init ? 1 : 2;
      2:       nst = bus.init ? 1 : ((bus.push || anyne) ? 3 : 2);
      default: nst = bus.init ? 1 : ((!anyne && !bus.push) ? 2 : 3);
    endcase
    if (bus.req) begin
      if (int'(bus.idx) < NV) begin m_co = m_words[bus.idx[VW-1:0]]; m_cv = 1; end
      else begin m_co = 0; m_cv = 0; end
    end else m_cv = 0;
    m_vld = '0;
    for (int c = 0; c < NV; c++) begin
      if (bus.pop[c] && m_st != 0) begin
        if (m_eg[c].size() > 0) begin
          exp_q[c].push_back(m_eg[c].pop_front());
          m_vld[c]   = 1'b1;
          m_words[c] = (m_words[c] + 1) % (1 << CW);
        end else m_err_pop = 1;
      end
    end
    if (disp) m_eg[d].push_back(m_in.pop_front());
    if (pok) m_in.push_back(bus.data_in);
    else if (bus.push) m_err_push = 1;
    if (m_st == 1 && bus.init) begin m_thl = int'(bus.umbral_L); m_thh = int'(bus.umbral_H); end
    m_st = nst;
  endtask

  // Monitor: compares status every cycle, pops the scoreboard on each valid pulse.
  always @(negedge clk) begin
    chk("state", 64'(bus.state), 64'(m_st));
    chk("idle", 64'(bus.idle), 64'(m_st == 2));
    chk("ingress_full", 64'(bus.ingress_full), 64'(m_in.size() == DEP));
    chk("err_push", 64'(bus.err_push), 64'(m_err_push));
    chk("err_pop", 64'(bus.err_pop), 64'(m_err_pop));
    chk("valid_out", 64'(bus.valid_out), 64'(m_vld));
    chk("cnt_valid", 64'(bus.cnt_valid), 64'(m_cv));
    chk("cnt_out", 64'(bus.cnt_out), 64'(m_co));
    for (int c = 0; c < NV; c++) begin
      chk("almost_empty", 64'(bus.almost_empty[c]), 64'(m_eg[c].size() <= m_thl));
      chk("almost_full", 64'(bus.almost_full[c]), 64'(m_eg[c].size() >= m_thh));
      if (bus.valid_out[c]) begin
        if (exp_q[c].size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL data_unexpected ch%0d: got %0h expected no word", c, bus.data_out[c*DW +: DW]);
        end else begin
          chk("data_out", 64'(bus.data_out[c*DW +: DW]), 64'(exp_q[c].pop_front()));
        end
      end
    end
  end

  task automatic drive(input bit ps, input logic [DW-1:0] d, input logic [NV-1:0] pp,
                       input bit rq, input logic [VW:0] ix, input bit it);
    bus.push = ps; bus.data_in = d; bus.pop = pp; bus.req = rq; bus.idx = ix; bus.init = it;
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, 0);
  endtask

  task automatic do_init(input int l, input int h);
    bus.umbral_L = TW'(l);
    bus.umbral_H = TW'(h);
    drive(0, '0, '0, 0, '0, 1);
    drive(0, '0, '0, 0, '0, 1);
    drive(0, '0, '0, 0, '0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int init_left;
    logic [DW-1:0] w;
    bus.push = 0; bus.data_in = '0; bus.pop = '0; bus.req = 0; bus.idx = '0;
    bus.init = 0; bus.umbral_L = '0; bus.umbral_H = '0;
    model_reset();

    // Reset and threshold load: state 0,1,1,2
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_data", 64'(bus.data_out), 64'd0);
    chk("rst_ae", 64'(bus.almost_empty), 64'hF);
    reset = 1'b1;
    bus.umbral_L = TW'(2); bus.umbral_H = TW'(6);
    drive(0, '0, '0, 0, '0, 1);
    chk("t1_state_a", 64'(bus.state), 64'd1);
    drive(0, '0, '0, 0, '0, 1);
    chk("t1_state_b", 64'(bus.state), 64'd1);
    drive(0, '0, '0, 0, '0, 0);
    chk("t1_state_c", 64'(bus.state), 64'd2);
    chk("t1_idle", 64'(bus.idle), 64'd1);

    // One word per channel, then a simultaneous pop
    drive(1, 12'h005, '0, 0, '0, 0);
    drive(1, 12'h412, '0, 0, '0, 0);
    drive(1, 12'h8AB, '0, 0, '0, 0);
    drive(1, 12'hC3F, '0, 0, '0, 0);
    idle_cyc(2);
    drive(0, '0, 4'b1111, 0, '0, 0);
    chk("t2_valid", 64'(bus.valid_out), 64'hF);
    chk("t2_data", 64'(bus.data_out), 64'hC3F_8AB_412_005);
    idle_cyc(1);
    chk("t2_valid_pulse", 64'(bus.valid_out), 64'h0);
    chk("t2_idle", 64'(bus.state), 64'd2);

    // Backpressure: egress 2 limited to 3 words, ingress fills to 8
    do_init(2, 3);
    for (int i = 0; i < 11; i++) drive(1, 12'h800 | DW'(i), '0, 0, '0, 0);
    chk("t3_af2", 64'(bus.almost_full[2]), 64'd1);
    chk("t3_full", 64'(bus.ingress_full), 64'd1);
    chk("t3_errpush0", 64'(bus.err_push), 64'd0);
    drive(1, 12'h8FF, '0, 0, '0, 0);
    chk("t3_errpush1", 64'(bus.err_push), 64'd1);
    drive(0, '0, 4'b0100, 0, '0, 0);
    chk("t3_full_hold", 64'(bus.ingress_full), 64'd1);
    idle_cyc(1);
    chk("t3_full_clr", 64'(bus.ingress_full), 64'd0);
    for (int i = 0; i < 60; i++) begin
      if (m_in.size() == 0 && m_eg[2].size() == 0) break;
      drive(0, '0, (m_eg[2].size() > 0) ? 4'b0100 : 4'b0000, 0, '0, 0);
    end
    chk("t3_drained", 64'(m_in.size() + m_eg[2].size()), 64'd0);

    // Pop on an empty channel
    chk("t4_errpop0", 64'(bus.err_pop), 64'd0);
    drive(0, '0, 4'b0010, 0, '0, 0);
    chk("t4_valid1", 64'(bus.valid_out[1]), 64'd0);
    chk("t4_hold1", 64'(bus.data_out[DW +: DW]), 64'h412);
    chk("t4_errpop1", 64'(bus.err_pop), 64'd1);

    // Counter readback: channel 3 already delivered one word earlier
    drive(1, 12'hC01, '0, 0, '0, 0);
    drive(1, 12'hC02, '0, 0, '0, 0);
    drive(1, 12'hC03, '0, 0, '0, 0);
    idle_cyc(2);
    for (int i = 0; i < 3; i++) drive(0, '0, 4'b1000, 0, '0, 0);
    drive(0, '0, '0, 1, 3'd3, 0);
    chk("t5_cv", 64'(bus.cnt_valid), 64'd1);
    chk("t5_cnt", 64'(bus.cnt_out), 64'd4);
    drive(0, '0, '0, 1, 3'd5, 0);
    chk("t5_cv_oob", 64'(bus.cnt_valid), 64'd0);
    chk("t5_cnt_oob", 64'(bus.cnt_out), 64'd0);

    // Asynchronous reset mid-cycle while channel 0 holds data
    drive(1, 12'h001, '0, 0, '0, 0);
    drive(1, 12'h002, '0, 0, '0, 0);
    idle_cyc(2);
    chk("t6_active", 64'(bus.state), 64'd3);
    @(posedge clk);
    model_step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_state", 64'(bus.state), 64'd0);
    chk("t6_data", 64'(bus.data_out), 64'd0);
    chk("t6_errpop", 64'(bus.err_pop), 64'd0);
    chk("t6_errpush", 64'(bus.err_push), 64'd0);
    chk("t6_cnt", 64'(bus.cnt_out), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(0, '0, '0, 0, '0, 1);
    do_init(2, 6);
    drive(0, '0, 4'b0001, 0, '0, 0);
    chk("t6_pop_empty_v", 64'(bus.valid_out[0]), 64'd0);
    chk("t6_pop_empty_e", 64'(bus.err_pop), 64'd1);

    // Random traffic with occasional threshold reloads
    init_left = 0;
    for (int k = 0; k < 700; k++) begin
      if (init_left == 0 && $urandom_range(0, 59) == 0) begin
        init_left    = $urandom_range(2, 3);
        bus.umbral_L = TW'($urandom_range(0, 9));
        bus.umbral_H = TW'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) bus.umbral_H = TW'($urandom_range(2, 8));
      end
      w = DW'($urandom);
      drive($urandom_range(0, 2) != 0, w, NV'($urandom & $urandom), $urandom_range(0, 3) == 0,
            (VW + 1)'($urandom), init_left > 0);
      if (init_left > 0) init_left--;
    end
    do_init(2, 6);
    for (int i = 0; i < 60; i++) drive(0, '0, 4'b1111, $urandom_range(0, 1) == 1, (VW + 1)'($urandom), 0);
    for (int c = 0; c < NV; c++) chk("sb_empty", 64'(exp_q[c].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
